// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the decoder scan sequencer.
// Holds the FSM state type, code width and code-to-select mapping.
package decoder_scan_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_t;

  // Returns {w0,w1,w2}: code bit2 drives w0, bit0 drives w2.
  function automatic logic [CODE_W-1:0] code_to_w(
    input logic [CODE_W-1:0] code
  );
    return {code[2], code[1], code[0]};
  endfunction

endpackage

// File: rtl/decoder_scan_sequencer_fifo.sv
// scan_fifo: DEPTH x CODE_W synchronous FIFO, sync active-high reset.
// Ports: push/din in, pop in, dout (head), count, full, empty out.
module scan_fifo
  import decoder_scan_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [CODE_W-1:0]          din,
  input  logic                       pop,
  output logic [CODE_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scan engine for a 3-to-8 enable decoder: buffers codes, drives w/en
// for DWELL cycles, samples f, returns {code,f} as a one-cycle pulse.
module decoder_scan_sequencer
  import decoder_scan_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DWELL = 2,
  parameter int GAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic              w0,
  output logic              w1,
  output logic              w2,
  output logic              en,
  input  logic              f,
  output logic              res_valid,
  output logic [CODE_W-1:0] res_code,
  output logic              res_f,
  output logic              busy
);

  localparam int CMAX  = (DWELL > GAP) ? DWELL : GAP;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int FCW   = $clog2(DEPTH) + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] w_q, w_d;
  logic              en_q, en_d;
  logic              res_valid_q, res_valid_d;
  logic [CODE_W-1:0] res_code_q, res_code_d;
  logic              res_f_q, res_f_d;

  logic              push, pop;
  logic              full, empty;
  logic [CODE_W-1:0] head;
  logic [FCW-1:0]    count;

  // Readiness uses the registered count, so a full FIFO refuses
  // a push even in the cycle it pops.
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == ST_IDLE) && !empty;

  scan_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_code),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      w_q         <= '0;
      en_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_code_q  <= '0;
      res_f_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      en_q        <= en_d;
      res_valid_q <= res_valid_d;
      res_code_q  <= res_code_d;
      res_f_q     <= res_f_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_DRIVE;
          cnt_d   = CNT_W'(DWELL - 1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(GAP - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_d         = w_q;
    en_d        = en_q;
    res_valid_d = 1'b0;
    res_code_d  = res_code_q;
    res_f_d     = res_f_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          w_d  = code_to_w(head);
          en_d = 1'b1;
        end else begin
          w_d  = '0;
          en_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        // f is only trusted at the last dwell edge.
        if (cnt_q == '0) begin
          res_f_d     = f;
          res_code_d  = w_q;
          res_valid_d = 1'b1;
          en_d        = 1'b0;
          w_d         = '0;
        end
      end
      ST_GAP: begin
        en_d = 1'b0;
        w_d  = '0;
      end
      default: begin
        en_d = 1'b0;
        w_d  = '0;
      end
    endcase
  end

  assign {w0, w1, w2} = w_q;
  assign en           = en_q;
  assign res_valid    = res_valid_q;
  assign res_code     = res_code_q;
  assign res_f        = res_f_q;
  assign busy         = (state_q != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench: three sequencer instances with different
// DWELL/GAP, a decoder truth-table model on f, and timing monitors.
module tb_decoder_scan_sequencer;

  localparam int N = 3;
  localparam logic [7:0] TT = 8'b0110_1001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid  [N];
  logic [2:0] in_code   [N];
  logic       in_ready  [N];
  logic       w0 [N], w1 [N], w2 [N], en [N];
  logic       res_valid [N];
  logic [2:0] res_code  [N];
  logic       res_f     [N];
  logic       busy      [N];

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                  nm, act, req, cyc);
  endtask

  for (genvar g = 0; g < N; g++) begin : u
    localparam int D = (g == 0) ? 2 : (g == 1) ? 8 : 1;
    localparam int G = (g == 2) ? 0 : 1;

    logic       f_l;
    logic [3:0] sbq [$];
    logic [3:0] e;
    logic [2:0] wv;
    int         acc, st, hi_run, lo_run;
    bit         seen_fall, exact, en_prev;

    decoder_scan_sequencer #(.DEPTH(4), .DWELL(D), .GAP(G)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_code   (in_code[g]),
      .in_ready  (in_ready[g]),
      .w0        (w0[g]),
      .w1        (w1[g]),
      .w2        (w2[g]),
      .en        (en[g]),
      .f         (f_l),
      .res_valid (res_valid[g]),
      .res_code  (res_code[g]),
      .res_f     (res_f[g]),
      .busy      (busy[g])
    );

    initial forever begin
      @(negedge clk);
      wv = {w0[g], w1[g], w2[g]};
      if (rst) begin
        sbq.delete();
        acc = 0; st = 0; hi_run = 0; lo_run = 0;
        seen_fall = 0; exact = 0; en_prev = 0;
        f_l = 1'($urandom);
      end else begin
        if (res_valid[g]) begin
          if (sbq.size() == 0) begin
            chk(0, "unexpected_result", int'(res_code[g]), -1);
          end else begin
            e = sbq.pop_front();
            chk(res_code[g] == e[3:1], "res_code",
                int'(res_code[g]), int'(e[3:1]));
            chk(res_f[g] == e[0], "res_f",
                int'(res_f[g]), int'(e[0]));
          end
        end
        if (en[g]) begin
          if (!en_prev) begin
            st++;
            if (seen_fall) begin
              if (exact) chk(lo_run == G + 1, "gap_exact", lo_run, G + 1);
              else       chk(lo_run >= G + 1, "gap_min", lo_run, G + 1);
            end
          end
          hi_run++;
          if (sbq.size() == 0) chk(0, "drive_without_code", int'(wv), -1);
          else chk(wv == sbq[0][3:1], "w_code", int'(wv), int'(sbq[0][3:1]));
        end else begin
          if (en_prev) begin
            chk(hi_run == D, "dwell_len", hi_run, D);
            hi_run = 0;
            lo_run = 0;
            seen_fall = 1;
            exact = (acc - st) > 0;
          end
          lo_run++;
          chk(wv == 3'b000, "w_idle", int'(wv), 0);
        end
        chk(in_ready[g] == ((acc - st) < 4), "in_ready",
            int'(in_ready[g]), int'((acc - st) < 4));
        en_prev = en[g];
        // Decoder model on the final dwell cycle, noise elsewhere.
        if (en[g] && hi_run == D) f_l = TT[wv];
        else f_l = 1'($urandom);
        if (in_valid[g] && in_ready[g]) begin
          sbq.push_back({in_code[g], TT[in_code[g]]});
          acc++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int g, input int first, input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 500) begin
      in_valid[g] = 1'b1;
      in_code[g]  = 3'(first + i);
      if (in_ready[g]) i++;
      tick();
      guard++;
    end
    in_valid[g] = 1'b0;
    chk(i == n, "push_timeout", i, n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy[0] || busy[1] || busy[2]) && k < 400) begin
      tick();
      k++;
    end
    chk(k < 400, "idle_timeout", k, 400);
    tick();
  endtask

  initial begin
    int r [$];
    rst = 1'b1;
    for (int g = 0; g < N; g++) begin
      in_valid[g] = 1'b0;
      in_code[g]  = 3'b000;
    end

    // Reset
    tick();
    tick();
    for (int g = 0; g < N; g++) begin
      chk(en[g] == 1'b0, "rst_en", int'(en[g]), 0);
      chk({w0[g], w1[g], w2[g]} == 3'b000, "rst_w",
          int'({w0[g], w1[g], w2[g]}), 0);
      chk(res_valid[g] == 1'b0, "rst_res_valid", int'(res_valid[g]), 0);
      chk(busy[g] == 1'b0, "rst_busy", int'(busy[g]), 0);
      chk(in_ready[g] == 1'b0, "rst_in_ready", int'(in_ready[g]), 0);
    end
    rst = 1'b0;
    #1;
    for (int g = 0; g < N; g++)
      chk(in_ready[g] == 1'b1, "post_rst_in_ready", int'(in_ready[g]), 1);

    // Single code latency
    in_valid[0] = 1'b1;
    in_code[0]  = 3'b101;
    tick();
    in_valid[0] = 1'b0;
    chk(en[0] == 1'b0, "t2_en_n", int'(en[0]), 0);
    tick();
    chk(en[0] == 1'b1, "t2_en_n1", int'(en[0]), 1);
    chk({w0[0], w1[0], w2[0]} == 3'b101, "t2_w_n1",
        int'({w0[0], w1[0], w2[0]}), 5);
    tick();
    chk(en[0] == 1'b1, "t2_en_n2", int'(en[0]), 1);
    tick();
    chk(en[0] == 1'b0, "t2_en_n3", int'(en[0]), 0);
    chk(res_valid[0] == 1'b1, "t2_res_valid", int'(res_valid[0]), 1);
    chk(res_code[0] == 3'b101, "t2_res_code", int'(res_code[0]), 5);
    chk(res_f[0] == TT[5], "t2_res_f", int'(res_f[0]), int'(TT[5]));
    wait_idle();

    // Full scan 0..7 with valid held
    push_n(0, 0, 8);
    wait_idle();

    // Full-with-pop behind a long dwell
    push_n(1, 3, 6);
    wait_idle();

    // DWELL=1, GAP=0 corner: 111 then 000
    push_n(2, 7, 2);
    repeat (10) begin
      if (res_valid[2]) r.push_back(cyc);
      tick();
    end
    chk(r.size() == 2, "t6_pulses", r.size(), 2);
    if (r.size() == 2) chk(r[1] - r[0] == 2, "t6_spacing", r[1] - r[0], 2);
    wait_idle();

    // Reset in the 2nd dwell cycle with two codes queued
    in_valid[0] = 1'b1;
    in_code[0]  = 3'b011;
    tick();
    in_code[0]  = 3'b001;
    tick();
    in_code[0]  = 3'b110;
    tick();
    in_valid[0] = 1'b0;
    chk(en[0] == 1'b1, "t5_pre_en", int'(en[0]), 1);
    chk({w0[0], w1[0], w2[0]} == 3'b011, "t5_pre_w",
        int'({w0[0], w1[0], w2[0]}), 3);
    rst = 1'b1;
    tick();
    chk(en[0] == 1'b0, "t5_en", int'(en[0]), 0);
    chk({w0[0], w1[0], w2[0]} == 3'b000, "t5_w",
        int'({w0[0], w1[0], w2[0]}), 0);
    chk(res_valid[0] == 1'b0, "t5_res_valid", int'(res_valid[0]), 0);
    chk(busy[0] == 1'b0, "t5_busy", int'(busy[0]), 0);
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk(res_valid[0] == 1'b0, "t5_no_pulse", int'(res_valid[0]), 0);
    end
    push_n(0, 4, 1);
    wait_idle();

    // Randomized traffic on all instances
    repeat (400) begin
      for (int g = 0; g < N; g++) begin
        in_valid[g] = 1'($urandom_range(0, 1));
        in_code[g]  = 3'($urandom);
      end
      tick();
    end
    for (int g = 0; g < N; g++) in_valid[g] = 1'b0;
    wait_idle();
    tick();

    chk(u[0].sbq.size() == 0, "sb0_drain", u[0].sbq.size(), 0);
    chk(u[1].sbq.size() == 0, "sb1_drain", u[1].sbq.size(), 0);
    chk(u[2].sbq.size() == 0, "sb2_drain", u[2].sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
